// File: rtl/mem_arbiter.sv
// mem_arbiter: core port 0 has absolute priority; port 1 is a one-entry
// buffered master with a starvation flag. Optional stats: MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W = $clog2(STARVE_LIMIT) + 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] p0_addr_i,
  input  logic        p0_rstrb_i,
  input  logic [3:0]  p0_wmask_i,
  input  logic [31:0] p0_wdata_i,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [3:0]  p1_wmask_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        starve_o,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0] p0_cnt_o,
  output logic [31:0] p1_cnt_o,
  output logic [31:0] conflict_cnt_o,
`endif
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o
);

  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;

  state_t      state, state_nx;
  logic        b_we;
  logic [29:0] b_word;
  logic [3:0]  b_wmask;
  logic [31:0] b_wdata;
  logic [CNT_W-1:0] cnt;
  logic        p0_active;
  logic        issue;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{p0_addr_i[1:0], p1_addr_i[1:0]};
  assign p0_active  = p0_rstrb_i | (|p0_wmask_i);
  assign issue      = (state == PEND) & ~p0_active;
  assign p0_rdata_o = mem_rdata_i;
  assign starve_o   = (cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    state_nx    = state;
    p1_ready_o  = 1'b0;
    p1_rvalid_o = 1'b0;
    mem_addr_o  = {p0_addr_i[31:2], 2'b00};
    mem_rstrb_o = p0_rstrb_i;
    mem_wmask_o = p0_wmask_i;
    mem_wdata_o = p0_wdata_i;
    unique case (state)
      IDLE: begin
        p1_ready_o = 1'b1;
        if (p1_valid_i) state_nx = PEND;
      end
      PEND: begin
        // the core has no stall input, so port 1 only uses idle core cycles
        if (!p0_active) begin
          mem_addr_o  = {b_word, 2'b00};
          mem_rstrb_o = ~b_we;
          mem_wmask_o = b_we ? b_wmask : 4'b0000;
          mem_wdata_o = b_wdata;
          state_nx    = RESP;
        end
      end
      RESP: begin
        p1_rvalid_o = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      b_we       <= 1'b0;
      b_word     <= '0;
      b_wmask    <= '0;
      b_wdata    <= '0;
      p1_rdata_o <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && p1_valid_i) begin
        b_we    <= p1_we_i;
        b_word  <= p1_addr_i[31:2];
        b_wmask <= p1_wmask_i;
        b_wdata <= p1_wdata_i;
      end
      if (issue && !b_we) p1_rdata_o <= mem_rdata_i;
      if (state != PEND || issue) cnt <= '0;
      else if (cnt < CNT_W'(STARVE_LIMIT)) cnt <= cnt + 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p0_cnt_o       <= '0;
      p1_cnt_o       <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (p0_active) p0_cnt_o <= p0_cnt_o + 1'b1;
      if (issue) p1_cnt_o <= p1_cnt_o + 1'b1;
      if (state == PEND && p0_active)
        conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end
`endif

endmodule
